// File: rtl/ex_stage.sv
// Execute stage: logic/shift/arith/move ALU, single-cycle multiply and a
// 32-step radix-2 restoring divider that stalls the pipeline while it runs.
`timescale 1ns/1ps
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_reg1,
  input  logic [31:0] ex_reg2,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [2:0]  ex_alusel,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [2:0] SEL_LOGIC  = 3'd1;
  localparam logic [2:0] SEL_SHIFT  = 3'd2;
  localparam logic [2:0] SEL_ARITH  = 3'd3;
  localparam logic [2:0] SEL_MOVE   = 3'd4;

  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_SLT   = 8'h2A;
  localparam logic [7:0] OP_SLTU  = 8'h2B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_ON   = 2'd2,
    S_END  = 2'd3
  } div_state_e;

  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;
  logic        neg_quo_q;
  logic        neg_rem_q;

  logic        is_div;
  logic        is_sdiv;
  logic        is_mult;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] trial;
  logic [32:0] diff;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [31:0] alu_res;

  assign is_div  = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);
  assign is_sdiv = (ex_aluop == OP_DIV);
  assign is_mult = (ex_aluop == OP_MULT) || (ex_aluop == OP_MULTU);

  assign abs1 = (is_sdiv && ex_reg1[31]) ? (32'd0 - ex_reg1) : ex_reg1;
  assign abs2 = (is_sdiv && ex_reg2[31]) ? (32'd0 - ex_reg2) : ex_reg2;

  // Partial remainder stays below the divisor, so trial - divisor fits in 32
  // bits whenever it is non-negative; bit 32 acts as the borrow.
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dvsr_q};

  always_comb begin
    if (!diff[32]) begin
      rem_d = diff[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end else begin
      rem_d = trial[31:0];
      quo_d = {quo_q[30:0], 1'b0};
    end
  end

  assign mul_a   = (ex_aluop == OP_MULT) ? {{32{ex_reg1[31]}}, ex_reg1} : {32'd0, ex_reg1};
  assign mul_b   = (ex_aluop == OP_MULT) ? {{32{ex_reg2[31]}}, ex_reg2} : {32'd0, ex_reg2};
  assign product = mul_a * mul_b;

  always_comb begin
    alu_res = 32'd0;
    case (ex_alusel)
      SEL_LOGIC: begin
        case (ex_aluop)
          OP_AND:  alu_res = ex_reg1 & ex_reg2;
          OP_OR:   alu_res = ex_reg1 | ex_reg2;
          OP_XOR:  alu_res = ex_reg1 ^ ex_reg2;
          OP_NOR:  alu_res = ~(ex_reg1 | ex_reg2);
          default: alu_res = 32'd0;
        endcase
      end
      SEL_SHIFT: begin
        case (ex_aluop)
          OP_SLL:  alu_res = ex_reg2 << ex_reg1[4:0];
          OP_SRL:  alu_res = ex_reg2 >> ex_reg1[4:0];
          OP_SRA:  alu_res = $signed(ex_reg2) >>> ex_reg1[4:0];
          default: alu_res = 32'd0;
        endcase
      end
      SEL_ARITH: begin
        case (ex_aluop)
          OP_ADDU: alu_res = ex_reg1 + ex_reg2;
          OP_SUBU: alu_res = ex_reg1 - ex_reg2;
          OP_SLT:  alu_res = {31'd0, ($signed(ex_reg1) < $signed(ex_reg2))};
          OP_SLTU: alu_res = {31'd0, (ex_reg1 < ex_reg2)};
          default: alu_res = 32'd0;
        endcase
      end
      SEL_MOVE: begin
        case (ex_aluop)
          OP_MFHI: alu_res = hi_i;
          OP_MFLO: alu_res = lo_i;
          default: alu_res = 32'd0;
        endcase
      end
      default: alu_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_div) begin
            if (ex_reg2 == 32'd0) begin
              state_q <= S_ZERO;
            end else begin
              quo_q     <= abs1;
              rem_q     <= 32'd0;
              dvsr_q    <= abs2;
              cnt_q     <= 6'd0;
              neg_quo_q <= is_sdiv && (ex_reg1[31] ^ ex_reg2[31]);
              neg_rem_q <= is_sdiv && ex_reg1[31];
              state_q   <= S_ON;
            end
          end
        end
        S_ZERO: begin
          quo_q     <= 32'd0;
          rem_q     <= 32'd0;
          neg_quo_q <= 1'b0;
          neg_rem_q <= 1'b0;
          state_q   <= S_END;
        end
        S_ON: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= S_END;
        end
        S_END:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    whilo_o    = 1'b0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = ex_wd;
      wreg_o     = ex_wreg;
      wdata_o    = alu_res;
      stallreq_o = ((state_q == S_IDLE) && is_div) || (state_q == S_ZERO) || (state_q == S_ON);
      if (state_q == S_END) begin
        whilo_o = 1'b1;
        hi_o    = neg_rem_q ? (32'd0 - rem_q) : rem_q;
        lo_o    = neg_quo_q ? (32'd0 - quo_q) : quo_q;
      end else if (is_mult) begin
        whilo_o = 1'b1;
        hi_o    = product[63:32];
        lo_o    = product[31:0];
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed corner cases plus random ALU/multiply/divide
// traffic checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_reg1, ex_reg2, hi_i, lo_i;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [2:0]  ex_alusel;
  logic [7:0]  ex_aluop;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int checks = 0;
  int failures = 0;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_alusel(ex_alusel), .ex_aluop(ex_aluop), .hi_i(hi_i), .lo_i(lo_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    ex_alusel = sel;
    ex_aluop  = op;
    ex_reg1   = a;
    ex_reg2   = b;
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] sel, input logic [7:0] op,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
    int unsigned sh;
    longint sa, sb;
    sh = a[4:0];
    sa = $signed(a);
    sb = $signed(b);
    if (sel == 3'd1 && op == 8'h24) return a & b;
    if (sel == 3'd1 && op == 8'h25) return a | b;
    if (sel == 3'd1 && op == 8'h26) return a ^ b;
    if (sel == 3'd1 && op == 8'h27) return ~(a | b);
    if (sel == 3'd2 && op == 8'h7C) return b << sh;
    if (sel == 3'd2 && op == 8'h02) return b >> sh;
    if (sel == 3'd2 && op == 8'h03) return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
    if (sel == 3'd3 && op == 8'h21) return a + b;
    if (sel == 3'd3 && op == 8'h23) return a - b;
    if (sel == 3'd3 && op == 8'h2A) return (sa < sb) ? 32'd1 : 32'd0;
    if (sel == 3'd3 && op == 8'h2B) return (a < b) ? 32'd1 : 32'd0;
    if (sel == 3'd4 && op == 8'h10) return hi;
    if (sel == 3'd4 && op == 8'h12) return lo;
    return 32'd0;
  endfunction

  function automatic logic [63:0] ref_mul(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, sp;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    sp = sa * sb;
    up = {32'd0, a} * {32'd0, b};
    return (op == 8'h18) ? sp : up;
  endfunction

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = {32'd0, a};
        sb = {32'd0, b};
      end
      qq = sa / sb;
      rr = sa % sb;
      q = qq[31:0];
      r = rr[31:0];
    end
  endtask

  // Issues a divide from IDLE, counts stall cycles and checks the END cycle.
  // keep=1 holds the same instruction past END so it is seen again in IDLE.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit sgn, input bit keep);
    logic [31:0] eq, er;
    int n, bad, exp_n;
    ref_div(a, b, sgn, eq, er);
    exp_n = (b == 32'd0) ? 2 : 33;
    drive(3'd5, sgn ? 8'h1A : 8'h1B, a, b);
    #1;
    n = 0;
    bad = 0;
    while (stallreq_o === 1'b1 && n < 40) begin
      if (whilo_o !== 1'b0) bad++;
      tick();
      #1;
      n++;
    end
    chk({tag, "_whilo_during_stall"}, bad, 0);
    chk({tag, "_stall_cycles"}, n, exp_n);
    chk({tag, "_end_stall"}, stallreq_o, 1'b0);
    chk({tag, "_end_whilo"}, whilo_o, 1'b1);
    chk({tag, "_end_hi"}, hi_o, er);
    chk({tag, "_end_lo"}, lo_o, eq);
    if (!keep) drive(3'd0, 8'h00, 32'd0, 32'd0);
    tick();
  endtask

  logic [10:0] op_tab [$];

  initial begin
    logic [10:0] ent;
    logic [31:0] a, b;
    logic [63:0] p;
    int bad;

    op_tab = '{ {3'd1,8'h24}, {3'd1,8'h25}, {3'd1,8'h26}, {3'd1,8'h27},
                {3'd2,8'h7C}, {3'd2,8'h02}, {3'd2,8'h03},
                {3'd3,8'h21}, {3'd3,8'h23}, {3'd3,8'h2A}, {3'd3,8'h2B},
                {3'd4,8'h10}, {3'd4,8'h12}, {3'd5,8'h18}, {3'd5,8'h19},
                {3'd0,8'h21}, {3'd6,8'h24}, {3'd7,8'h10}, {3'd1,8'h21},
                {3'd2,8'h24}, {3'd3,8'h7C}, {3'd4,8'h25}, {3'd1,8'h55} };

    // Reset: all outputs forced low even with a multiply on the inputs.
    rst = 1'b1;
    ex_wd = 5'd17; ex_wreg = 1'b1; hi_i = 32'h1234_5678; lo_i = 32'h9ABC_DEF0;
    drive(3'd5, 8'h18, 32'hFFFF_FFFE, 32'd3);
    tick(); tick();
    #1;
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_whilo", whilo_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_stall", stallreq_o, 0);
    rst = 1'b0;
    tick();

    drive(3'd3, 8'h21, 32'hFFFF_FFFF, 32'd2); #1;
    chk("addu_wrap", wdata_o, 32'd1);
    chk("addu_wreg", wreg_o, 1'b1);
    chk("addu_wd", wd_o, 5'd17);
    drive(3'd3, 8'h2A, 32'hFFFF_FFFF, 32'd1); #1;
    chk("slt_neg", wdata_o, 32'd1);
    drive(3'd3, 8'h2B, 32'hFFFF_FFFF, 32'd1); #1;
    chk("sltu_big", wdata_o, 32'd0);
    drive(3'd2, 8'h03, 32'd4, 32'hF000_0000); #1;
    chk("sra_4", wdata_o, 32'hFF00_0000);
    drive(3'd2, 8'h02, 32'd4, 32'hF000_0000); #1;
    chk("srl_4", wdata_o, 32'h0F00_0000);
    drive(3'd2, 8'h7C, 32'hFFFF_FFFF, 32'd3); #1;
    chk("sll_31", wdata_o, 32'h8000_0000);
    drive(3'd5, 8'h18, 32'hFFFF_FFFE, 32'd3); #1;
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFA);
    chk("mult_whilo", whilo_o, 1'b1);
    chk("mult_stall", stallreq_o, 1'b0);
    drive(3'd1, 8'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF); #1;
    chk("nonmul_whilo", whilo_o, 1'b0);
    chk("nonmul_hilo", {hi_o, lo_o}, 64'd0);
    tick();

    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_div("divu_by0", 32'd10, 32'd0, 1'b0, 1'b0);
    run_div("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Back-to-back: instruction still present after END starts a new divide.
    run_div("b2b_first", 32'd1000, 32'd33, 1'b0, 1'b1);
    run_div("b2b_second", 32'hFFFF_FC18, 32'd7, 1'b1, 1'b0);

    // Reset in the middle of a divide discards it.
    drive(3'd5, 8'h1B, 32'd12345, 32'd17); #1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (whilo_o !== 1'b0 || stallreq_o !== 1'b1) bad++;
    end
    #1;
    chk("mid_div_running", bad, 0);
    rst = 1'b1; #1;
    chk("mid_rst_stall", stallreq_o, 1'b0);
    chk("mid_rst_whilo", whilo_o, 1'b0);
    tick();
    rst = 1'b0;
    drive(3'd0, 8'h00, 32'd0, 32'd0); #1;
    chk("post_rst_idle_stall", stallreq_o, 1'b0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) bad++;
    end
    chk("post_rst_no_whilo", bad, 0);
    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0);

    // Random ALU / multiply traffic.
    for (int i = 0; i < 80; i++) begin
      ent = op_tab[$urandom_range(op_tab.size() - 1)];
      a = $urandom;
      b = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
      ex_wd = 5'($urandom_range(31));
      ex_wreg = 1'($urandom_range(1));
      hi_i = $urandom;
      lo_i = $urandom;
      drive(ent[10:8], ent[7:0], a, b); #1;
      chk("rnd_wdata", wdata_o, ref_alu(ent[10:8], ent[7:0], a, b, hi_i, lo_i));
      chk("rnd_wd_wreg", {wd_o, wreg_o}, {ex_wd, ex_wreg});
      chk("rnd_stall", stallreq_o, 1'b0);
      if (ent[7:0] == 8'h18 || ent[7:0] == 8'h19) begin
        p = ref_mul(ent[7:0], a, b);
        chk("rnd_mul", {whilo_o, hi_o, lo_o}, {1'b1, p});
      end else begin
        chk("rnd_nomul", {whilo_o, hi_o, lo_o}, 65'd0);
      end
      tick();
    end

    // Random divides, occasionally by zero or with small divisors.
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = 32'd0;
        1: b = 32'($urandom_range(15)) + 32'd1;
        2: b = 32'd0 - (32'($urandom_range(15)) + 32'd1);
        default: b = $urandom;
      endcase
      run_div("rnd_div", a, b, 1'(i % 2), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
